// File: rtl/pong_pkg.sv
// pong_pkg: screen/paddle geometry, FSM states and the direction type shared by the ball engine.
package pong_pkg;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_SIZE    = 16;
    localparam int PADDLE_Y_TOP = 320;
    localparam int PADDLE_WIDTH = 96;
    localparam int SPEED        = 2;
    localparam int MAX_SPEED    = 6;
    localparam int SERVE_FRAMES = 60;
    localparam logic [9:0] X_CENTRE      = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [8:0] Y_CENTRE      = 9'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [8:0] Y_PADDLE_REST = 9'(PADDLE_Y_TOP - BALL_SIZE);
    typedef enum logic [1:0] {SERVE, RUN, MISS} state_t;
    typedef enum logic {DIR_NEG, DIR_POS} dir_t;
    function automatic dir_t flip(dir_t d);
        return d == DIR_POS ? DIR_NEG : DIR_POS;
    endfunction
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one motion step along a single axis, reflecting between 0 and LIMIT.
module ball_axis
    import pong_pkg::*;
#(
    parameter int W     = 10,
    parameter int LIMIT = H_ACTIVE - BALL_SIZE
) (
    input  logic [W-1:0] pos,
    input  dir_t         dir,
    input  logic [2:0]   step,
    output logic [W-1:0] next_pos,
    output dir_t         next_dir,
    output logic         hit
);
    localparam logic [W:0] LIM = (W + 1)'(LIMIT);
    logic [W:0] s_ext, fwd;
    assign s_ext    = {{(W - 2){1'b0}}, step};
    assign fwd      = {1'b0, pos} + s_ext;
    assign hit      = dir == DIR_POS ? fwd >= LIM : {1'b0, pos} < s_ext;
    assign next_pos = hit ? (dir == DIR_POS ? LIM[W-1:0] : '0)
                          : (dir == DIR_POS ? fwd[W-1:0] : pos - s_ext[W-1:0]);
    assign next_dir = hit ? flip(dir) : dir;
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball motion, paddle/wall reflection, miss detection and ball pixel strobe.
// Define PONG_BALL_SPEEDUP_EN to add one pixel/frame of speed per paddle hit, capped at MAX_SPEED.
module pong_ball_engine
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_x,
    input  logic [8:0] counter_y,
    input  logic       in_display_area,
    input  logic       frame_tick,
    input  logic [9:0] paddle_left,
    output logic       ball_pixel,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       bounce,
    output logic       miss
);
    localparam logic [10:0] BS11 = 11'(BALL_SIZE);
    localparam logic [10:0] PT11 = 11'(PADDLE_Y_TOP);
    localparam logic [10:0] PW11 = 11'(PADDLE_WIDTH);
    localparam logic [10:0] VA11 = 11'(V_ACTIVE);
    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx;
    dir_t        dx, dy, dx_nx, dy_nx, ax_dir;
    logic [9:0]  x_nx, ax_pos;
    logic [8:0]  y_nx;
    logic        ax_hit, paddle_hit, floor_miss, top_hit, pix_nx, bounce_nx, miss_nx;
    logic [10:0] y_ext, s11, bot, nbot, nx_ext, pl_ext;
    logic [2:0]  speed;
`ifdef PONG_BALL_SPEEDUP_EN
    logic [2:0]  speed_nx;
`else
    assign speed = 3'(SPEED);
`endif

    ball_axis #(.W(10), .LIMIT(H_ACTIVE - BALL_SIZE)) u_axis_x (
        .pos      (ball_x),
        .dir      (dx),
        .step     (speed),
        .next_pos (ax_pos),
        .next_dir (ax_dir),
        .hit      (ax_hit)
    );

    assign y_ext      = {2'b0, ball_y};
    assign s11        = {8'b0, speed};
    assign bot        = y_ext + BS11;
    assign nbot       = bot + s11;
    assign nx_ext     = {1'b0, ax_pos};
    assign pl_ext     = {1'b0, paddle_left};
    // Paddle overlap is judged at the ball's new x so corner hits land on the right paddle pixels.
    assign paddle_hit = dy == DIR_POS && bot <= PT11 && PT11 < nbot
                        && nx_ext + BS11 > pl_ext && nx_ext < pl_ext + PW11;
    assign floor_miss = dy == DIR_POS && !paddle_hit && nbot >= VA11;
    assign top_hit    = dy == DIR_NEG && y_ext < s11;
    assign pix_nx     = in_display_area
                        && counter_x >= ball_x && {1'b0, counter_x} < {1'b0, ball_x} + BS11
                        && counter_y >= ball_y && {2'b0, counter_y} < y_ext + BS11;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        x_nx      = ball_x;
        y_nx      = ball_y;
        dx_nx     = dx;
        dy_nx     = dy;
        bounce_nx = 1'b0;
        miss_nx   = 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
        speed_nx  = speed;
`endif
        if (frame_tick) begin
            if (state == RUN) begin
                if (floor_miss) begin
                    state_nx = MISS;
                    cnt_nx   = '0;
                    x_nx     = X_CENTRE;
                    y_nx     = Y_CENTRE;
                    dx_nx    = flip(dx);
                    dy_nx    = DIR_POS;
                    miss_nx  = 1'b1;
`ifdef PONG_BALL_SPEEDUP_EN
                    speed_nx = 3'(SPEED);
`endif
                end else begin
                    x_nx      = ax_pos;
                    dx_nx     = ax_dir;
                    y_nx      = top_hit ? '0 : paddle_hit ? Y_PADDLE_REST :
                                dy == DIR_POS ? ball_y + {6'b0, speed} : ball_y - {6'b0, speed};
                    dy_nx     = (top_hit || paddle_hit) ? flip(dy) : dy;
                    bounce_nx = ax_hit | top_hit | paddle_hit;
`ifdef PONG_BALL_SPEEDUP_EN
                    speed_nx  = (paddle_hit && speed < 3'(MAX_SPEED)) ? speed + 3'd1 : speed;
`endif
                end
            end else if (cnt == 6'(SERVE_FRAMES - 1)) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SERVE;
            cnt        <= '0;
            ball_x     <= X_CENTRE;
            ball_y     <= Y_CENTRE;
            dx         <= DIR_POS;
            dy         <= DIR_POS;
            ball_pixel <= 1'b0;
            bounce     <= 1'b0;
            miss       <= 1'b0;
`ifdef PONG_BALL_SPEEDUP_EN
            speed      <= 3'(SPEED);
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            ball_x     <= x_nx;
            ball_y     <= y_nx;
            dx         <= dx_nx;
            dy         <= dy_nx;
            ball_pixel <= pix_nx;
            bounce     <= bounce_nx;
            miss       <= miss_nx;
`ifdef PONG_BALL_SPEEDUP_EN
            speed      <= speed_nx;
`endif
        end
    end
endmodule
